// File: rtl/ram_dp_pkg.sv
// ram_dp_pkg: shared FSM states, read-during-write policy codes and lane parity helper
package ram_dp_pkg;
  typedef enum logic {INIT, RUN} state_e;
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;
  function automatic logic lane_parity(input logic [7:0] lane);
    return ^lane;
  endfunction
endpackage

// File: rtl/ram_dp_param_if.sv
// ram_dp_param_if: write/read port bundle of the dual-port RAM; parity signals exist only with RAM_PARITY_EN
interface ram_dp_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) ();
  localparam int LANES = DATA_WIDTH / 8;
  logic                  write;
  logic [ADDR_WIDTH-1:0] wr_address;
  logic [LANES-1:0]      wr_be;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  read;
  logic [ADDR_WIDTH-1:0] rd_address;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  init_done;
`ifdef RAM_PARITY_EN
  logic [LANES-1:0]      par_flip;
  logic                  parity_err;
  modport master (output write, wr_address, wr_be, data_in, read, rd_address, par_flip,
                  input data_out, rd_valid, init_done, parity_err);
  modport slave (input write, wr_address, wr_be, data_in, read, rd_address, par_flip,
                 output data_out, rd_valid, init_done, parity_err);
`else
  modport master (output write, wr_address, wr_be, data_in, read, rd_address,
                  input data_out, rd_valid, init_done);
  modport slave (input write, wr_address, wr_be, data_in, read, rd_address,
                 output data_out, rd_valid, init_done);
`endif
endinterface

// File: rtl/ram_dp_init_ctrl.sv
// ram_dp_init_ctrl: post-reset sweep that zeroes every address, then holds RUN until the next reset
module ram_dp_init_ctrl
  import ram_dp_pkg::*;
#(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  init_we,
  output logic [ADDR_WIDTH-1:0] init_addr,
  output logic                  init_done
);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  always_comb begin
    state_d    = (state_q == INIT && &init_cnt_q) ? RUN : state_q;
    init_cnt_d = (state_q == INIT) ? init_cnt_q + 1'b1 : init_cnt_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end
  assign init_we   = state_q == INIT;
  assign init_addr = init_cnt_q;
  assign init_done = state_q == RUN;
endmodule

// File: rtl/ram_dp_param.sv
// ram_dp_param: byte-enable dual-port RAM with registered read and init sweep; RAM_PARITY_EN adds per-lane parity
module ram_dp_param
  import ram_dp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int RDW_MODE   = RDW_OLD
) (
  input logic           clock,
  input logic           reset,
  ram_dp_param_if.slave bus
);
  localparam int LANES = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  init_we, init_done, we, re, collide;
  logic [ADDR_WIDTH-1:0] init_addr, wa;
  logic [DATA_WIDTH-1:0] wr_word, rd_word, data_out_q, data_out_d;
  logic                  rd_valid_q, rd_valid_d;
  ram_dp_init_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) u_init (
    .clock     (clock),
    .reset     (reset),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_done (init_done)
  );
  // the init sweep owns the write port until RUN; user requests are simply not accepted before then
  always_comb begin
    re      = init_done & bus.read;
    we      = !reset & (init_we | (init_done & bus.write));
    wa      = init_we ? init_addr : bus.wr_address;
    wr_word = '0;
    for (int i = 0; i < LANES; i++)
      wr_word[8*i+:8] = init_we ? 8'h00 : bus.wr_be[i] ? bus.data_in[8*i+:8] : mem_q[wa][8*i+:8];
    collide    = RDW_MODE == RDW_NEW && we && wa == bus.rd_address;
    rd_word    = collide ? wr_word : mem_q[bus.rd_address];
    data_out_d = re ? rd_word : data_out_q;
    rd_valid_d = re;
  end
  always_ff @(posedge clock) if (we) mem_q[wa] <= wr_word;
  always_ff @(posedge clock) begin
    if (reset) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
    end
  end
  assign bus.data_out  = data_out_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.init_done = init_done;
`ifdef RAM_PARITY_EN
  logic [LANES-1:0] par_q [DEPTH];
  logic [LANES-1:0] wr_par, rd_par, chk_par;
  logic             parity_err_q, parity_err_d;
  // disabled lanes keep their stored parity so an injected error survives partial writes
  always_comb begin
    wr_par  = '0;
    chk_par = '0;
    for (int i = 0; i < LANES; i++) begin
      wr_par[i]  = init_we ? 1'b0 : bus.wr_be[i] ? lane_parity(bus.data_in[8*i+:8]) ^ bus.par_flip[i] : par_q[wa][i];
      chk_par[i] = lane_parity(rd_word[8*i+:8]);
    end
    rd_par       = collide ? wr_par : par_q[bus.rd_address];
    parity_err_d = re & (rd_par != chk_par);
  end
  always_ff @(posedge clock) if (we) par_q[wa] <= wr_par;
  always_ff @(posedge clock) parity_err_q <= reset ? 1'b0 : parity_err_d;
  assign bus.parity_err = parity_err_q;
`endif
endmodule

// File: tb/tb_ram_dp_param.sv
// tb_ram_dp_param: scoreboard bench driving an old-data and a new-data RAM with identical directed stimulus
module tb_ram_dp_param;
  import ram_dp_pkg::*;
  typedef struct packed {logic pe; logic [31:0] d;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  ram_dp_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) if0 ();
  ram_dp_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) if1 ();
  ram_dp_param #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .RDW_MODE(RDW_OLD)) u0 (.clock(clk), .reset(rst), .bus(if0.slave));
  ram_dp_param #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .RDW_MODE(RDW_NEW)) u1 (.clock(clk), .reset(rst), .bus(if1.slave));
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [5:0] wa, input logic [3:0] be, input logic [31:0] d,
                       input logic r, input logic [5:0] ra, input logic [3:0] pf);
    if0.write = w; if0.wr_address = wa; if0.wr_be = be; if0.data_in = d; if0.read = r; if0.rd_address = ra;
    if1.write = w; if1.wr_address = wa; if1.wr_be = be; if1.data_in = d; if1.read = r; if1.rd_address = ra;
`ifdef RAM_PARITY_EN
    if0.par_flip = pf; if1.par_flip = pf;
`else
    if (pf != 4'h0) $display("note: par_flip ignored without parity");
`endif
  endtask

  task automatic req(input logic w, input logic [5:0] wa, input logic [3:0] be, input logic [31:0] d,
                     input logic r, input logic [5:0] ra, input logic [3:0] pf);
    drive(w, wa, be, d, r, ra, pf);
    cyc();
    drive(1'b0, 6'd0, 4'h0, 32'h0, 1'b0, 6'd0, 4'h0);
  endtask

  task automatic expect2(input logic [31:0] d0, input logic [31:0] d1, input logic pe);
    q0.push_back('{pe: pe, d: d0});
    q1.push_back('{pe: pe, d: d1});
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (if0.rd_valid === 1'b1) begin
      if (q0.size() == 0) check("dut0 unexpected rd_valid", 64'd1, 64'd0);
      else begin
        e = q0.pop_front();
        check("dut0 data_out", {32'h0, if0.data_out}, {32'h0, e.d});
`ifdef RAM_PARITY_EN
        check("dut0 parity_err", {63'h0, if0.parity_err}, {63'h0, e.pe});
`endif
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (if1.rd_valid === 1'b1) begin
      if (q1.size() == 0) check("dut1 unexpected rd_valid", 64'd1, 64'd0);
      else begin
        e = q1.pop_front();
        check("dut1 data_out", {32'h0, if1.data_out}, {32'h0, e.d});
`ifdef RAM_PARITY_EN
        check("dut1 parity_err", {63'h0, if1.parity_err}, {63'h0, e.pe});
`endif
      end
    end
  end

  initial begin
    int   n;
    logic bad;
    drive(1'b0, 6'd0, 4'h0, 32'h0, 1'b0, 6'd0, 4'h0);
    cyc();
    cyc();
    check("reset data_out", {32'h0, if0.data_out}, 64'h0);
    check("reset rd_valid", {63'h0, if0.rd_valid}, 64'h0);
    check("reset init_done", {63'h0, if0.init_done}, 64'h0);
    check("reset init_done dut1", {63'h0, if1.init_done}, 64'h0);
`ifdef RAM_PARITY_EN
    check("reset parity_err", {63'h0, if0.parity_err}, 64'h0);
`endif
    // requests held during INIT must be ignored
    rst = 1'b0;
    drive(1'b1, 6'd7, 4'hF, 32'hFFFF_FFFF, 1'b1, 6'd7, 4'h0);
    n = 0;
    bad = 1'b0;
    while (if0.init_done !== 1'b1 && n < 200) begin
      cyc();
      n++;
      if (if0.rd_valid === 1'b1 || if1.rd_valid === 1'b1) bad = 1'b1;
      if (if0.init_done === 1'b1) drive(1'b0, 6'd0, 4'h0, 32'h0, 1'b0, 6'd0, 4'h0);
    end
    check("init cycles", 64'(n), 64'd64);
    check("init_done dut1", {63'h0, if1.init_done}, 64'h1);
    check("rd_valid during init", {63'h0, bad}, 64'h0);
    for (int a = 0; a < 64; a++) begin
      expect2(32'h0, 32'h0, 1'b0);
      req(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, a[5:0], 4'h0);
    end
    // byte-enable merge
    req(1'b1, 6'd5, 4'hF, 32'hDEAD_BEEF, 1'b0, 6'd0, 4'h0);
    req(1'b1, 6'd5, 4'b0010, 32'h0000_AA00, 1'b0, 6'd0, 4'h0);
    expect2(32'hDEAD_AAEF, 32'hDEAD_AAEF, 1'b0);
    req(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd5, 4'h0);
    // read-during-write collision
    req(1'b1, 6'd9, 4'hF, 32'h1111_1111, 1'b0, 6'd0, 4'h0);
    expect2(32'h1111_1111, 32'h1111_2222, 1'b0);
    req(1'b1, 6'd9, 4'b0011, 32'h2222_2222, 1'b1, 6'd9, 4'h0);
    expect2(32'h1111_2222, 32'h1111_2222, 1'b0);
    req(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd9, 4'h0);
    // different addresses and an all-zero byte enable
    expect2(32'h0, 32'h0, 1'b0);
    req(1'b1, 6'd10, 4'hF, 32'hAAAA_AAAA, 1'b1, 6'd11, 4'h0);
    req(1'b1, 6'd5, 4'h0, 32'h0, 1'b0, 6'd0, 4'h0);
    expect2(32'hDEAD_AAEF, 32'hDEAD_AAEF, 1'b0);
    req(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd5, 4'h0);
    expect2(32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0);
    req(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd10, 4'h0);
    cyc();
    check("data_out hold", {32'h0, if0.data_out}, 64'h0000_0000_AAAA_AAAA);
    check("rd_valid idle", {63'h0, if0.rd_valid}, 64'h0);
`ifdef RAM_PARITY_EN
    req(1'b1, 6'd3, 4'hF, 32'h0000_00FF, 1'b0, 6'd0, 4'b0100);
    expect2(32'h0000_00FF, 32'h0000_00FF, 1'b1);
    req(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd3, 4'h0);
    expect2(32'hDEAD_AAEF, 32'hDEAD_AAEF, 1'b0);
    req(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd5, 4'h0);
`endif
    // reset mid-operation drops a read and restarts the sweep
    req(1'b1, 6'd40, 4'hF, 32'h1234_5678, 1'b0, 6'd0, 4'h0);
    rst = 1'b1;
    drive(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd40, 4'h0);
    cyc();
    rst = 1'b0;
    drive(1'b0, 6'd0, 4'h0, 32'h0, 1'b0, 6'd0, 4'h0);
    check("rd_valid after reset", {63'h0, if0.rd_valid}, 64'h0);
    for (int i = 0; i < 30; i++) cyc();
    check("init_done mid sweep", {63'h0, if0.init_done}, 64'h0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n = 0;
    while (if0.init_done !== 1'b1 && n < 200) begin
      cyc();
      n++;
    end
    check("re-init cycles", 64'(n), 64'd64);
    expect2(32'h0, 32'h0, 1'b0);
    req(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd40, 4'h0);
    expect2(32'h0, 32'h0, 1'b0);
    req(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd5, 4'h0);
    cyc();
    cyc();
    check("dut0 queue drained", 64'(q0.size()), 64'd0);
    check("dut1 queue drained", 64'(q1.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_dp_param.md
# ram_dp_param

Parametrised synchronous dual-port RAM: next-generation storage for the dual-port RAM testbench environment, with independent write and read ports on one clock. Adds configurable width and depth, per-byte write enables, a registered read with `rd_valid`, and a selectable read-during-write policy. A post-reset hardware initialisation sweep zeroes every location. Optional per-byte parity is available.

## Interface
- `DATA_WIDTH`, 32: word width in bits; must be a multiple of 8. LANES = DATA_WIDTH/8.
- `ADDR_WIDTH`, 6: address width; DEPTH = 2**ADDR_WIDTH.
- `RDW_MODE`, 0: same-address read-during-write. 0 = old data, 1 = new (merged) data.

Ports:
- `clock` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `write` in 1: write request.
- `wr_address` in ADDR_WIDTH: write address.
- `wr_be` in LANES: byte enables; bit i covers data bits [8i+7:8i].
- `data_in` in DATA_WIDTH: write data.
- `read` in 1: read request.
- `rd_address` in ADDR_WIDTH: read address.
- `data_out` out DATA_WIDTH: registered read data.
- `rd_valid` out 1: `data_out` carries a fresh read result this cycle.
- `init_done` out 1: high once the init sweep has completed.
- `par_flip` in LANES: present only with `RAM_PARITY_EN`. Inverts the stored parity bit per lane on write; used for error injection.
- `parity_err` out 1: present only with `RAM_PARITY_EN`.

## Operation
- FSM states: INIT and RUN.
  - `reset` forces INIT and sets `init_cnt` = 0.
  - In INIT, the block writes zero (and zero parity) to address `init_cnt` each cycle, then increments `init_cnt`.
  - When `init_cnt` = DEPTH-1 is written, the FSM moves to RUN.
  - RUN is held until the next `reset`.
- In INIT, `write` and `read` are ignored and `rd_valid` stays 0.
- Write (RUN, `write`=1): for each lane with `wr_be[i]`=1, `mem[wr_address]` lane i ← `data_in` lane i. Other lanes are unchanged. `wr_be`=0 is a legal no-op.
- Read (RUN, `read`=1): `data_out` ← `mem[rd_address]`, and `rd_valid`=1 the next cycle.
- With no read, `data_out` holds its last value and `rd_valid`=0.
- Same-address collision (both requests in the same cycle):
  - RDW_MODE 0: returns the pre-write word.
  - RDW_MODE 1: returns, per lane, `data_in` where `wr_be` is set, otherwise the old lane.
- Different addresses never interact.
- Addresses are always in range because DEPTH = 2**ADDR_WIDTH.
- A `reset` asserted mid-operation restarts INIT from address 0. Any read in flight is dropped: `rd_valid`=0 the next cycle.

## Timing
- Reset values: `data_out`=0, `rd_valid`=0, `init_done`=0, `parity_err`=0.
- Init duration: DEPTH cycles after `reset` deasserts. `init_done` rises on the cycle after the last init write; the first accepted request is on that cycle.
- Read latency: 1 cycle, from the request edge to `data_out`/`rd_valid`.
- Write latency: written data is visible to a read issued the following cycle.
- Throughput: one write and one read every cycle, with no stalls in RUN.

## Configuration
- `RAM_PARITY_EN` defined:
  - Each lane stores an extra even-parity bit, computed as ^(lane data) XOR `par_flip[i]` at write time.
  - On read, the block recomputes parity for all lanes. `parity_err` is registered with `rd_valid` and is 1 if any lane mismatches; it is 0 when `rd_valid`=0.
  - In RDW_MODE 1 collisions, checking uses the merged word and its newly computed parity.
- `RAM_PARITY_EN` undefined: no parity storage, and no `par_flip`/`parity_err` ports.

## Structure
- Package `ram_dp_pkg` holds:
  - the state enum {INIT, RUN};
  - the RDW_MODE constants RDW_OLD=0 and RDW_NEW=1;
  - a `lane_parity` function.
- Sub-module `ram_dp_init_ctrl` owns the FSM and `init_cnt`. It outputs `init_we`, `init_addr` and `init_done`; the top level muxes the init write over the user write port.

## Test plan
- Reset, then idle: `init_done` rises exactly DEPTH=64 cycles after `reset` falls. Reading all 64 addresses returns 0x00000000 with `rd_valid` one cycle after each read.
- Write 0xDEADBEEF with `wr_be`=4'hF to address 5, then `wr_be`=4'b0010 with `data_in`=0x0000AA00 to address 5. A read of address 5 returns 0xDEADAAEF.
- Write 0x11111111 to address 9. Next, with RDW_MODE=0, write 0x22222222 and read address 9 in the same cycle: returns 0x11111111. With RDW_MODE=1, `wr_be`=4'b0011: returns 0x11112222.
- Issue `read` and `write` during INIT: `rd_valid` stays 0 and memory stays zero after `init_done`.
- Assert `reset` for 1 cycle when `init_cnt`=30: `init_done` stays 0 for a further 64 cycles. A previously written address 40 reads 0.
- With `RAM_PARITY_EN`: write address 3 with `par_flip`=4'b0100, then read it: `parity_err`=1 with `rd_valid`. A clean address gives `parity_err`=0.
